// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// A clock divider produces one pixel strobe every CLK_DIV clocks; horizontal and
// vertical counters advance on that strobe, and all sync/blanking decodes are
// registered from the next-count values so they never skew against pix_x/pix_y.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 4,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int X_W       = 10,
    parameter int Y_W       = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic           pix_tick,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           video_on,
    output logic           hsync,
    output logic           vsync,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // A one-bit divider counter is kept even for CLK_DIV=1; it simply stays at 0.
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0]   H_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]   V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]   HS_FIRST = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0]   VS_FIRST = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Reject timing sets the counters cannot represent.
    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            CLK_DIV < 1 || H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_bad_params
            $error("vga_timing_gen: unsupported parameter set");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [X_W-1:0]   h_cnt_q, h_cnt_d;
    logic [Y_W-1:0]   v_cnt_q, v_cnt_d;
    logic             video_on_q, video_on_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             div_last;

    // Pixel strobe: last clock of each pixel period while the raster runs.
    always_comb begin
        div_last  = (div_cnt_q == DIV_LAST);
        pix_tick  = en && div_last;
        div_cnt_d = div_cnt_q;
        if (en) begin
            div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
        end
    end

    // Raster counters: x wraps at end of line and carries into y.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Decodes from the next-count values so the registered strobes line up with pix_x/pix_y.
    always_comb begin
        video_on_d    = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
        hsync_d       = ((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST)) ? HSYNC_POL : !HSYNC_POL;
        vsync_d       = ((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST)) ? VSYNC_POL : !VSYNC_POL;
        line_start_d  = (h_cnt_d == '0);
        frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end

    // State registers; reset parks the raster on the last back-porch pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            video_on_q    <= 1'b0;
            hsync_q       <= !HSYNC_POL;
            vsync_q       <= !VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_x       = h_cnt_q;
    assign pix_y       = v_cnt_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny
// instance with positive sync polarity share clk/rst/en.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;

    logic       tick_a, von_a, hs_a, vs_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       tick_b, von_b, hs_b, vs_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst), .en(en),
        .pix_tick(tick_a), .pix_x(x_a), .pix_y(y_a), .video_on(von_a),
        .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .pix_tick(tick_b), .pix_x(x_b), .pix_y(y_b), .video_on(von_b),
        .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, div;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        bit tick; int x; int y; bit von; bit hs; bit vs; bit ls; bit fs;
    } exp_t;

    typedef struct {
        bit rst; bit en; int ncyc;
        bit tick; int x; int y; bit von; bit hs; bit vs; bit ls; bit fs;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: after e enabled clocks since reset, e/div pixels have elapsed
    // starting from the last pixel of the frame; position follows by arithmetic.
    function automatic exp_t model(input cfg_t c, input longint e, input bit en_now);
        exp_t   r;
        longint ht  = c.ha + c.hf + c.hs + c.hb;
        longint vt  = c.va + c.vf + c.vs + c.vb;
        longint idx = (ht * vt - 1 + e / c.div) % (ht * vt);
        r.x    = int'(idx % ht);
        r.y    = int'(idx / ht);
        r.tick = en_now && ((e % c.div) == c.div - 1);
        r.von  = (r.x < c.ha) && (r.y < c.va);
        r.hs   = (r.x >= c.ha + c.hf && r.x < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
        r.vs   = (r.y >= c.va + c.vf && r.y < c.va + c.vf + c.vs) ? c.vp : !c.vp;
        r.ls   = (r.x == 0);
        r.fs   = (r.x == 0) && (r.y == 0);
        return r;
    endfunction

    task automatic chk_all(input string tag, input exp_t ex,
                           input logic tk, input logic [9:0] x, input logic [9:0] y,
                           input logic von, input logic hs, input logic vs,
                           input logic ls, input logic fs);
        chk({tag, " pix_tick"},    int'(tk),  int'(ex.tick));
        chk({tag, " pix_x"},       int'(x),   ex.x);
        chk({tag, " pix_y"},       int'(y),   ex.y);
        chk({tag, " video_on"},    int'(von), int'(ex.von));
        chk({tag, " hsync"},       int'(hs),  int'(ex.hs));
        chk({tag, " vsync"},       int'(vs),  int'(ex.vs));
        chk({tag, " line_start"},  int'(ls),  int'(ex.ls));
        chk({tag, " frame_start"}, int'(fs),  int'(ex.fs));
    endtask

    initial begin
        vec_t   tbl[17];
        cfg_t   ca, cb;
        exp_t   ex;
        longint e;
        int     rise_a[$];
        int     rise_b[$];
        int     hs_low, von_hi, tick_b_low;
        bit     prev_ls, prev_fs;

        ca = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0};
        cb = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1'b1, 1'b1};

        //          rst   en    ncyc  tick  x    y    von   hs    vs    ls    fs
        tbl[0]  = '{1'b1, 1'b0, 2,    1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3,    1'b1, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1,    1'b0, 0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 3,    1'b1, 0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1,    1'b0, 1,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 10,   1'b0, 1,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2,    1'b0, 1,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 5,    1'b0, 1,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2,    1'b0, 2,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2616, 1'b0, 656, 0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 383,  1'b1, 751, 0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1,    1'b0, 752, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 188,  1'b0, 799, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 4,    1'b0, 0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 42,   1'b0, 10,  1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 0,    1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 4,    1'b0, 0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Directed table on the default instance: reset, first pixel, en freeze, one line, mid-line reset.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst = tbl[i].rst;
            en  = tbl[i].en;
            repeat (tbl[i].ncyc) @(posedge clk);
            #1;
            ex = '{tbl[i].tick, tbl[i].x, tbl[i].y, tbl[i].von, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs};
            chk_all($sformatf("vec%0d", i), ex, tick_a, x_a, y_a, von_a, hs_a, vs_a, ls_a, fs_a);
        end

        // Random en / occasional reset, both instances against the arithmetic model.
        e = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            rst = (i == 0) || ($urandom_range(0, 2999) == 0);
            en  = ($urandom_range(0, 9) < 8);
            #1;
            if (rst) e = 0;
            chk_all("rand_a", model(ca, e, en), tick_a, x_a, y_a, von_a, hs_a, vs_a, ls_a, fs_a);
            chk_all("rand_b", model(cb, e, en), tick_b, x_b, y_b, von_b, hs_b, vs_b, ls_b, fs_b);
            @(posedge clk);
            if (!rst && en) e++;
        end

        // Continuous run: line period, hsync width/offset, active width, tiny-frame period.
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev_ls = ls_a;
        prev_fs = fs_b;
        hs_low = 0; von_hi = 0; tick_b_low = 0;
        for (int t = 1; t <= 3300; t++) begin
            @(negedge clk);
            if (!tick_b) tick_b_low++;
            if (ls_a && !prev_ls) rise_a.push_back(t);
            if (fs_b && !prev_fs) rise_b.push_back(t);
            if (rise_a.size() == 1) begin
                if (!hs_a) hs_low++;
                if (von_a) von_hi++;
            end
            prev_ls = ls_a;
            prev_fs = fs_b;
        end
        chk("first line_start clks", rise_a.size() > 0 ? rise_a[0] : -1, 4);
        chk("line_start count", rise_a.size(), 2);
        if (rise_a.size() >= 2) chk("line period clks", rise_a[1] - rise_a[0], 3200);
        chk("hsync low clks", hs_low, 384);
        chk("video_on clks", von_hi, 2560);
        chk("small pix_tick low clks", tick_b_low, 0);
        chk("small frame count", rise_b.size() >= 2 ? 1 : 0, 1);
        if (rise_b.size() >= 2) chk("small frame period", rise_b[1] - rise_b[0], 48);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 sync logic driving `hsync`/`vsync`/`rgb` in `main`.
- Generalised in four ways:
  - every horizontal and vertical timing field is a parameter;
  - the pixel-clock divide ratio is a parameter;
  - sync polarity is a parameter;
  - an enable pauses the raster.
- Outputs pixel coordinates and strobes that downstream pixel/colour logic uses to generate `rgb`.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (≥1); 100 MHz / 4 = 25 MHz
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync
- X_W, 10, width of pix_x; must hold H_TOTAL-1
- Y_W, 10, width of pix_y; must hold V_TOTAL-1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  1 = raster runs; 0 = all state frozen
- pix_tick  out  1  combinational strobe, 1 on the clk cycle where the pixel counters advance
- pix_x  out  X_W  current horizontal count, 0..H_TOTAL-1
- pix_y  out  Y_W  current vertical count, 0..V_TOTAL-1
- video_on  out  1  1 when pix_x < H_ACTIVE and pix_y < V_ACTIVE
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- line_start  out  1  1 while pix_x == 0
- frame_start  out  1  1 while pix_x == 0 and pix_y == 0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 on each clk while en=1, then wraps to 0.
  - pix_tick = en && (div_cnt == CLK_DIV-1).
  - CLK_DIV=1: pix_tick = en.
- Counters:
  - On a clk edge with pix_tick=1, h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt at V_TOTAL-1 with an h wrap goes to 0.
  - pix_x = h_cnt, pix_y = v_cnt.
- Decodes: video_on, hsync, vsync, line_start and frame_start are registered. They update on the same edge as the counters, from the next-count values, so they are always consistent with pix_x/pix_y, with zero skew.
- hsync asserted iff H_ACTIVE+H_FP ≤ pix_x ≤ H_ACTIVE+H_FP+H_SYNC-1; otherwise at the level ~HSYNC_POL.
- vsync asserted iff V_ACTIVE+V_FP ≤ pix_y ≤ V_ACTIVE+V_FP+V_SYNC-1; vsync edges coincide with pix_x wrapping to 0.
- Reset (asynchronous, immediate):
  - div_cnt = 0.
  - pix_x = H_TOTAL-1, pix_y = V_TOTAL-1.
  - video_on = 0, line_start = 0, frame_start = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - The reset state is therefore a consistent back-porch position.
- First pix_tick after reset release (CLK_DIV clks after release, with en=1) moves to (0,0): frame_start=1, line_start=1, video_on=1.
- en=0: div_cnt, counters and all registered outputs hold; pix_tick=0. Deasserting and re-asserting en resumes mid-pixel from the held div_cnt.
- Reset asserted mid-frame: the state returns to the reset values on that instant, regardless of en.
- Line/frame strobes last one full pixel period (CLK_DIV clks when en=1).
- Static checks: if any timing field is 0, or CLK_DIV < 1, the block is unsupported. Elaboration flags this via a generate-time error.

Test Plan:
- Default params, en=1, release rst:
  - first pix_tick 4 clks after release;
  - pix_x=0, pix_y=0, frame_start=1, video_on=1 after that edge;
  - frame_start stays high exactly 4 clks.
- Default params, one line:
  - hsync low for exactly 384 clks (96 px), starting 2624 clks (656 px) after line_start rises;
  - line period 3200 clks;
  - video_on high 2560 clks per visible line.
- Default params, full frame:
  - frame_start period 1,680,000 clks;
  - vsync low exactly 6400 clks (2 lines), beginning when pix_y becomes 490 at pix_x=0;
  - video_on never high for pix_y ≥ 480.
- Small params (H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, HSYNC_POL=1, VSYNC_POL=1):
  - pix_x cycles 0..7, pix_y cycles 0..5;
  - hsync high only at pix_x 5,6;
  - vsync high only at pix_y 4;
  - pix_tick constantly 1.
- en pulled low for 10 clks mid-line at pix_x=100:
  - all outputs frozen for 10 clks;
  - after en returns, pix_x reaches 101 in (4 - held div_cnt) clks;
  - total line period 3210 clks.
- rst asserted at pix_x=300, pix_y=200:
  - outputs immediately go to pix_x=799, pix_y=524, video_on=0, hsync=vsync=1;
  - after release, behaviour matches the first scenario.
